// File: rtl/apb_reg_slave.sv
// ---------------------------------------------------------------------------
// apb_reg_slave
//
// APB completer holding NUM_REGS 32-bit read/write registers at word-aligned
// offsets from BASE_ADDR, with WAIT_STATES cycles of pready=0 at the start of
// every ACCESS phase. The full register file is exposed on regs_flat as a
// back-door observation path.
//
// Parameters
//   NUM_REGS    : number of registers (1..64)
//   WAIT_STATES : pready-low cycles per ACCESS phase (0..15)
//   BASE_ADDR   : byte address of register 0, aligned to the register window
//
// Ports
//   clk        in   clock, rising-edge
//   rst        in   asynchronous active-high reset
//   psel       in   slave select
//   penable    in   ACCESS phase indicator
//   pwrite     in   1 = write, 0 = read
//   paddr      in   byte address (bits [1:0] ignored)
//   pwdata     in   write data
//   prdata     out  read data, held between transfers
//   pready     out  transfer completes when psel & penable & pready
//   pslverr    out  error response, valid with pready
//   regs_flat  out  register i at bits [32*i+31:32*i]
//
// Optional feature
//   APB_SLV_PSLVERR_EN : when defined, out-of-range accesses return
//                        pslverr=1; otherwise pslverr is always 0.
//                        Out-of-range writes are dropped and reads return 0
//                        in both builds.
// ---------------------------------------------------------------------------
module apb_reg_slave #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [31:0]                paddr,
    input  logic [31:0]                pwdata,
    output logic [31:0]                prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [32*NUM_REGS-1:0]     regs_flat
);

    localparam int unsigned IDXW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

`ifdef APB_SLV_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              wr_q;
    logic              range_q;
    logic [IDXW-1:0]   idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       prdata_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [31:0]       regs_q [NUM_REGS];

    // Address decode. BASE_ADDR is window-aligned, so the word offset can be
    // taken from the upper address bits alone; the full-width compare keeps
    // addresses just below the base out of range.
    logic [29:0]       word_off;
    logic              in_range;
    logic [IDXW-1:0]   idx;

    assign word_off = paddr[31:2] - BASE_ADDR[31:2];
    assign in_range = (paddr >= BASE_ADDR) && (word_off < 30'(NUM_REGS));
    assign idx      = word_off[IDXW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            range_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    // penable without psel (or with psel outside SETUP) is ignored here.
                    if (psel && !penable) begin
                        state_q <= S_ACCESS;
                        wr_q    <= pwrite;
                        range_q <= in_range;
                        idx_q   <= idx;
                        wdata_q <= pwdata;
                        cnt_q   <= WAIT_INIT;
                        if (!pwrite) begin
                            prdata_q <= in_range ? regs_q[idx] : '0;
                        end
                        // pready is registered, so with no wait states it must
                        // be raised on the SETUP edge to appear in the first
                        // ACCESS cycle.
                        if (WAIT_INIT == 4'd0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= ERR_EN && !in_range;
                        end
                    end
                end

                S_ACCESS: begin
                    if (!(psel && penable)) begin
                        // Master abandoned the transfer: no write, no error.
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                        // Raise pready one edge early so it is seen in the
                        // cycle where the counter reads zero.
                        if (cnt_q == 4'd1) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= ERR_EN && !range_q;
                        end
                    end else begin
                        if (wr_q && range_q) begin
                            regs_q[idx_q] <= wdata_q;
                        end
                        state_q   <= S_IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
            endcase
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_flat[32*i +: 32] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
module tb_apb_reg_slave;

    localparam int unsigned N    = 8;
    localparam int unsigned WS   = 3;
    localparam logic [31:0] BASE = 32'h0000_0400;

`ifdef APB_SLV_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [32*N-1:0]   regs_flat;

    apb_reg_slave #(
        .NUM_REGS    (N),
        .WAIT_STATES (WS),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .regs_flat (regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            wr;
        logic [31:0]     rdata;
        logic            err;
        logic [32*N-1:0] flat;
    } exp_t;

    exp_t            sbq[$];
    exp_t            e;
    logic [31:0]     mdl [N];
    int              checks = 0;
    int              fails  = 0;
    logic [32*N-1:0] last_flat = '0;
    logic [32*N-1:0] pend_flat = '0;
    logic            pend      = 1'b0;
    logic [31:0]     last_rd   = '0;
    int              cyc       = 0;

    task automatic chk(input string name, input logic [32*N-1:0] act, input logic [32*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        longint unsigned aa = a;
        longint unsigned bb = BASE;
        return (aa >= bb) && (aa < bb + 4 * N);
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a - BASE) / 4;
    endfunction

    function automatic logic [32*N-1:0] mdl_flat();
        logic [32*N-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[32*i +: 32] = mdl[i];
        return f;
    endfunction

    // Monitor: compares every completed transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
        end else begin
            if (pend) begin
                chk("backdoor_after_xfer", regs_flat, pend_flat);
                last_flat = pend_flat;
                pend = 1'b0;
            end
            if (psel && !penable) cyc = 1;
            else if (psel && penable) cyc++;
            if (psel && penable && pready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_completion: got pready=1 expected no transfer (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("xfer_len", cyc, 2 + WS);
                    chk("pslverr", pslverr, e.err);
                    if (!e.wr) begin
                        chk("prdata", prdata, e.rdata);
                        last_rd = e.rdata;
                    end
                    chk("no_early_commit", regs_flat, last_flat);
                    pend_flat = e.flat;
                    pend = 1'b1;
                end
            end else if (!psel) begin
                chk("idle_pready", pready, 0);
                chk("prdata_hold", prdata, last_rd);
            end
        end
    end

    // Issue one transfer starting at posedge+1; returns at posedge+1 after
    // completion (psel still high) so the next call is back-to-back.
    // abort_k > 0 drops psel after abort_k ACCESS cycles instead.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data, input int abort_k);
        exp_t x;
        logic done;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk);
        #1;
        penable = 1'b1;
        if (abort_k > 0) begin
            repeat (abort_k) begin
                @(posedge clk);
                #1;
            end
            psel    = 1'b0;
            penable = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        x.wr    = wr;
        x.err   = ERR_EN && !in_rng(addr);
        x.rdata = (!wr && in_rng(addr)) ? mdl[idx_of(addr)] : 32'h0;
        if (wr && in_rng(addr)) mdl[idx_of(addr)] = data;
        x.flat  = mdl_flat();
        sbq.push_back(x);
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (pready) done = 1'b1;
            else pwdata = $urandom;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL xfer_timeout: got no pready expected completion within 50 cycles (addr %0h)", addr);
            sbq.delete();
            psel    = 1'b0;
            penable = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        psel    = 1'b0;
        penable = logic'($urandom_range(0, 1));
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        penable = 1'b0;
    endtask

    task automatic reset_mid_access();
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = BASE + 32'h8;
        pwdata  = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_prdata", prdata, 0);
        chk("rst_mid_pready", pready, 0);
        chk("rst_mid_pslverr", pslverr, 0);
        chk("rst_mid_regs", regs_flat, 0);
        for (int i = 0; i < N; i++) mdl[i] = '0;
        sbq.delete();
        pend      = 1'b0;
        last_flat = '0;
        last_rd   = '0;
        psel      = 1'b0;
        penable   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic        wr;
        logic [31:0] addr;
        int          r;
        int          ab;
        for (int i = 0; i < N; i++) mdl[i] = '0;
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        #3;
        rst = 1'b1;
        #1;
        chk("reset_prdata", prdata, 0);
        chk("reset_pready", pready, 0);
        chk("reset_pslverr", pslverr, 0);
        chk("reset_regs", regs_flat, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        xfer(1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 0);
        xfer(1'b0, BASE + 32'h08, 32'h0, 0);
        idle(2);
        xfer(1'b1, BASE + 32'h20, 32'h1234_5678, 0);
        xfer(1'b0, BASE + 32'h20, 32'h0, 0);
        idle(1);
        xfer(1'b1, BASE + 32'h04, 32'h0000_0001, 0);
        xfer(1'b1, BASE + 32'h0C, 32'h0000_0002, 0);
        xfer(1'b0, BASE + 32'h04, 32'h0, 0);
        idle(1);
        xfer(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 2);
        xfer(1'b0, BASE + 32'h10, 32'h0, 0);
        xfer(1'b0, BASE - 32'h4, 32'h0, 0);
        xfer(1'b1, BASE + 32'h1F, 32'h0000_0077, 0);
        xfer(1'b0, BASE + 32'h1C, 32'h0, 0);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            wr = logic'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            if (r < 8)
                addr = BASE + 4 * $urandom_range(0, N - 1) + $urandom_range(0, 3);
            else if (r == 8)
                addr = BASE + 4 * N + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            else if ($urandom_range(0, 1) == 0)
                addr = BASE - 1 - $urandom_range(0, 255);
            else
                addr = $urandom;
            ab = (wr && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, WS - 1)) : 0;
            xfer(wr, addr, $urandom, ab);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        xfer(1'b1, BASE + 32'h08, 32'hCAFE_F00D, 0);
        xfer(1'b0, BASE + 32'h08, 32'h0, 0);
        reset_mid_access();
        xfer(1'b0, BASE + 32'h08, 32'h0, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
